rename_regfile: RTL and testbench

- Parametrised architectural register file with rename-status tracking for the out-of-order core.
- Sits between Decoder/Dispatch, ReorderBuffer and the reservation stations.
- Holds committed values, plus a busy bit and an owning-ROB tag per register.
- Adds the following over the previous two-port, one-commit design: NRP read ports, NCP commit ports, same-cycle commit bypass to readers, and a registered busy-register counter.

---
 rtl/rename_regfile.sv | 151 +++++++++++++++
 tb/tb_rename_regfile.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_regfile.sv
// rename_regfile
//   Architectural register file with rename-status tracking. Each register
//   holds a committed value, a busy bit and the ROB tag of its pending producer.
//   Register 0 always reads as zero and is never written or marked busy.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (global stall when low)
//   flush_in                          : clear all busy bits and tags
//   cm_valid/cm_reg/cm_tag/cm_val     : NCP commit ports, port k+1 is younger
//   ds_valid/ds_reg/ds_tag            : dispatch rename of one destination
//   rd_reg -> rd_val/rd_busy/rd_tag   : NRP combinational operand read ports
//   rob_qtag -> rob_qready/rob_qval   : per-port ROB lookup of the pending tag
//   busy_cnt                          : registered count of busy registers
module rename_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned REG_W = $clog2(NREG),
  parameter int unsigned ROB_W = 4,
  parameter int unsigned NRP   = 2,
  parameter int unsigned NCP   = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic [NCP-1:0]        cm_valid,
  input  logic [NCP*REG_W-1:0]  cm_reg,
  input  logic [NCP*ROB_W-1:0]  cm_tag,
  input  logic [NCP*XLEN-1:0]   cm_val,
  input  logic                  ds_valid,
  input  logic [REG_W-1:0]      ds_reg,
  input  logic [ROB_W-1:0]      ds_tag,
  input  logic [NRP*REG_W-1:0]  rd_reg,
  output logic [NRP*XLEN-1:0]   rd_val,
  output logic [NRP-1:0]        rd_busy,
  output logic [NRP*ROB_W-1:0]  rd_tag,
  output logic [NRP*ROB_W-1:0]  rob_qtag,
  input  logic [NRP-1:0]        rob_qready,
  input  logic [NRP*XLEN-1:0]   rob_qval,
  output logic [REG_W:0]        busy_cnt
);

  localparam int unsigned CNT_W = REG_W + 1;

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [ROB_W-1:0] tag_q  [NREG];
  logic [ROB_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [CNT_W-1:0] busy_cnt_q;
  logic [CNT_W-1:0] busy_cnt_d;

  // Next-state: commits in ascending port order so the youngest write wins,
  // then flush or dispatch, which override any commit-side busy clear.
  always_comb begin : next_state
    logic [REG_W-1:0] cr;
    cr         = '0;
    regs_d     = regs_q;
    tag_d      = tag_q;
    busy_d     = busy_q;
    busy_cnt_d = '0;
    if (rdy_in) begin
      for (int unsigned k = 0; k < NCP; k++) begin
        cr = cm_reg[k*REG_W +: REG_W];
        if (cm_valid[k] && (cr != '0)) begin
          regs_d[cr] = cm_val[k*XLEN +: XLEN];
          if (cm_tag[k*ROB_W +: ROB_W] == tag_q[cr]) begin
            busy_d[cr] = 1'b0;
          end
        end
      end
      if (flush_in) begin
        busy_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
          tag_d[i] = '0;
        end
      end else if (ds_valid && (ds_reg != '0)) begin
        busy_d[ds_reg] = 1'b1;
        tag_d[ds_reg]  = ds_tag;
      end
    end
    for (int unsigned i = 0; i < NREG; i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Operand read: dispatch forward, then same-cycle commit bypass (highest
  // matching port wins), then ROB result, then stored state.
  always_comb begin : read_ports
    logic [REG_W-1:0] r;
    logic             cm_hit;
    logic [XLEN-1:0]  cm_v;
    r        = '0;
    cm_hit   = 1'b0;
    cm_v     = '0;
    rd_val   = '0;
    rd_busy  = '0;
    rd_tag   = '0;
    rob_qtag = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      r      = rd_reg[p*REG_W +: REG_W];
      cm_hit = 1'b0;
      cm_v   = '0;
      rob_qtag[p*ROB_W +: ROB_W] = tag_q[r];
      for (int unsigned k = 0; k < NCP; k++) begin
        if (cm_valid[k] && (cm_reg[k*REG_W +: REG_W] == r) &&
            (cm_tag[k*ROB_W +: ROB_W] == tag_q[r])) begin
          cm_hit = 1'b1;
          cm_v   = cm_val[k*XLEN +: XLEN];
        end
      end
      if (r == '0) begin
        rd_val[p*XLEN +: XLEN] = '0;
      end else if (ds_valid && (ds_reg == r)) begin
        rd_busy[p]               = 1'b1;
        rd_tag[p*ROB_W +: ROB_W] = ds_tag;
        rd_val[p*XLEN +: XLEN]   = regs_q[r];
      end else if (busy_q[r] && cm_hit) begin
        rd_val[p*XLEN +: XLEN] = cm_v;
      end else if (busy_q[r] && rob_qready[p]) begin
        rd_val[p*XLEN +: XLEN] = rob_qval[p*XLEN +: XLEN];
      end else if (busy_q[r]) begin
        rd_busy[p]               = 1'b1;
        rd_tag[p*ROB_W +: ROB_W] = tag_q[r];
        rd_val[p*XLEN +: XLEN]   = regs_q[r];
      end else begin
        rd_val[p*XLEN +: XLEN] = regs_q[r];
      end
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: expected outputs are queued when the
// stimulus is applied and popped/compared once the outputs have settled.
module tb_rename_regfile;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned ROB_W = 4;
  localparam int unsigned NRP   = 2;
  localparam int unsigned NCP   = 2;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 rdy_in;
  logic                 flush_in;
  logic [NCP-1:0]       cm_valid;
  logic [NCP*REG_W-1:0] cm_reg;
  logic [NCP*ROB_W-1:0] cm_tag;
  logic [NCP*XLEN-1:0]  cm_val;
  logic                 ds_valid;
  logic [REG_W-1:0]     ds_reg;
  logic [ROB_W-1:0]     ds_tag;
  logic [NRP*REG_W-1:0] rd_reg;
  logic [NRP*XLEN-1:0]  rd_val;
  logic [NRP-1:0]       rd_busy;
  logic [NRP*ROB_W-1:0] rd_tag;
  logic [NRP*ROB_W-1:0] rob_qtag;
  logic [NRP-1:0]       rob_qready;
  logic [NRP*XLEN-1:0]  rob_qval;
  logic [REG_W:0]       busy_cnt;

  rename_regfile #(
    .XLEN (XLEN),
    .NREG (NREG),
    .ROB_W(ROB_W),
    .NRP  (NRP),
    .NCP  (NCP)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .cm_valid  (cm_valid),
    .cm_reg    (cm_reg),
    .cm_tag    (cm_tag),
    .cm_val    (cm_val),
    .ds_valid  (ds_valid),
    .ds_reg    (ds_reg),
    .ds_tag    (ds_tag),
    .rd_reg    (rd_reg),
    .rd_val    (rd_val),
    .rd_busy   (rd_busy),
    .rd_tag    (rd_tag),
    .rob_qtag  (rob_qtag),
    .rob_qready(rob_qready),
    .rob_qval  (rob_qval),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef enum int { K_VAL, K_BUSY, K_TAG, K_QTAG, K_CNT } kind_e;

  typedef struct {
    string       name;
    kind_e       kind;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string name, input kind_e kind, input int port,
                      input logic [63:0] exp);
    exp_t e;
    e.name = name; e.kind = kind; e.port = port; e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] observe(input kind_e kind, input int port);
    case (kind)
      K_VAL:   return 64'(rd_val[port*XLEN +: XLEN]);
      K_BUSY:  return 64'(rd_busy[port]);
      K_TAG:   return 64'(rd_tag[port*ROB_W +: ROB_W]);
      K_QTAG:  return 64'(rob_qtag[port*ROB_W +: ROB_W]);
      default: return 64'(busy_cnt);
    endcase
  endfunction

  // Queue the full operand view expected on one read port.
  task automatic exp_rd(input string name, input int port, input logic [63:0] val,
                        input logic [63:0] busy, input logic [63:0] tag);
    push({name, "_val"}, K_VAL, port, val);
    push({name, "_busy"}, K_BUSY, port, busy);
    if (busy == 64'd1) push({name, "_tag"}, K_TAG, port, tag);
  endtask

  task automatic settle();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, observe(e.kind, e.port), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    flush_in   = 1'b0;
    cm_valid   = '0;
    cm_reg     = '0;
    cm_tag     = '0;
    cm_val     = '0;
    ds_valid   = 1'b0;
    ds_reg     = '0;
    ds_tag     = '0;
    rob_qready = '0;
    rob_qval   = '0;
  endtask

  task automatic set_cm(input int k, input logic [REG_W-1:0] r,
                        input logic [ROB_W-1:0] t, input logic [XLEN-1:0] v);
    cm_valid[k]               = 1'b1;
    cm_reg[k*REG_W +: REG_W]  = r;
    cm_tag[k*ROB_W +: ROB_W]  = t;
    cm_val[k*XLEN +: XLEN]    = v;
  endtask

  task automatic dispatch(input logic [REG_W-1:0] r, input logic [ROB_W-1:0] t);
    ds_valid = 1'b1; ds_reg = r; ds_tag = t;
    tick();
    idle();
  endtask

  task automatic set_rd(input logic [REG_W-1:0] r0, input logic [REG_W-1:0] r1);
    rd_reg = {r1, r0};
  endtask

  initial begin
    idle();
    rdy_in = 1'b1;
    rst_in = 1'b0;
    set_rd(5'd5, 5'd0);
    exp_rd("rst_r5", 0, 0, 0, 0);
    exp_rd("rst_r0", 1, 0, 0, 0);
    push("rst_cnt", K_CNT, 0, 0);
    settle();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    tick();

    // Rename r3 -> tag 7, then observe it busy.
    dispatch(5'd3, 4'd7);
    set_rd(5'd3, 5'd0);
    exp_rd("ds_r3", 0, 0, 1, 7);
    push("ds_r3_qtag", K_QTAG, 0, 7);
    push("ds_cnt", K_CNT, 0, 1);
    settle();

    // ROB already holds the result for tag 7.
    rob_qready = 2'b01; rob_qval[31:0] = 32'h1234_5678;
    exp_rd("rob_fwd", 0, 32'h1234_5678, 0, 0);
    settle();
    idle();

    // Same-cycle dispatch forward to port 1 (not ticked).
    set_rd(5'd0, 5'd3);
    ds_valid = 1'b1; ds_reg = 5'd3; ds_tag = 4'd2;
    exp_rd("dsfwd", 1, 0, 1, 2);
    settle();
    idle();

    // Commit bypass of r3 tag 7.
    set_rd(5'd3, 5'd0);
    set_cm(0, 5'd3, 4'd7, 32'hDEAD_BEEF);
    exp_rd("cm_byp", 0, 32'hDEAD_BEEF, 0, 0);
    settle();
    tick();
    idle();
    exp_rd("cm_after", 0, 32'hDEAD_BEEF, 0, 0);
    push("cm_after_cnt", K_CNT, 0, 0);
    settle();

    // Two commit ports to the same register: the younger port wins.
    dispatch(5'd5, 4'd3);
    set_rd(5'd5, 5'd5);
    set_cm(0, 5'd5, 4'd3, 32'hAAAA_0001);
    set_cm(1, 5'd5, 4'd3, 32'hBBBB_0002);
    exp_rd("dual_byp", 1, 32'hBBBB_0002, 0, 0);
    settle();
    tick();
    idle();
    exp_rd("dual_reg", 0, 32'hBBBB_0002, 0, 0);
    push("dual_cnt", K_CNT, 0, 0);
    settle();

    // Tag mismatch keeps busy; then commit + dispatch same register.
    dispatch(5'd4, 4'd9);
    set_cm(0, 5'd4, 4'd5, 32'h11);
    tick();
    idle();
    set_rd(5'd4, 5'd0);
    exp_rd("mism", 0, 32'h11, 1, 9);
    push("mism_cnt", K_CNT, 0, 1);
    settle();
    set_cm(0, 5'd4, 4'd9, 32'h22);
    dispatch(5'd4, 4'd12);
    exp_rd("cmds", 0, 32'h22, 1, 12);
    push("cmds_cnt", K_CNT, 0, 1);
    settle();

    // Busy r1, r2, r6 (r4 still busy).
    dispatch(5'd1, 4'd1);
    dispatch(5'd2, 4'd2);
    dispatch(5'd6, 4'd6);
    push("pre_fl_cnt", K_CNT, 0, 4);
    settle();

    // Flush + commit while stalled: nothing changes.
    rdy_in = 1'b0; flush_in = 1'b1;
    set_cm(0, 5'd2, 4'd0, 32'h42);
    tick();
    idle();
    rdy_in = 1'b1;
    set_rd(5'd2, 5'd6);
    exp_rd("stall_r2", 0, 0, 1, 2);
    push("stall_cnt", K_CNT, 0, 4);
    settle();

    // Flush with a commit of r2; dispatch in the flush cycle is ignored.
    flush_in = 1'b1;
    set_cm(0, 5'd2, 4'd0, 32'h42);
    dispatch(5'd7, 4'd8);
    set_rd(5'd2, 5'd6);
    exp_rd("fl_r2", 0, 32'h42, 0, 0);
    exp_rd("fl_r6", 1, 0, 0, 0);
    push("fl_qtag", K_QTAG, 1, 0);
    push("fl_cnt", K_CNT, 0, 0);
    settle();
    set_rd(5'd7, 5'd4);
    exp_rd("fl_r7", 0, 0, 0, 0);
    exp_rd("fl_r4", 1, 32'h22, 0, 0);
    settle();

    // Register 0 ignores dispatch and commit.
    set_rd(5'd0, 5'd0);
    set_cm(1, 5'd0, 4'd0, 32'hFF);
    ds_valid = 1'b1; ds_reg = 5'd0; ds_tag = 4'd5;
    exp_rd("r0_same", 0, 0, 0, 0);
    settle();
    tick();
    idle();
    exp_rd("r0_after", 1, 0, 0, 0);
    push("r0_cnt", K_CNT, 0, 0);
    settle();

    // Asynchronous reset mid-operation, while stalled.
    dispatch(5'd7, 4'd4);
    push("pre_rst_cnt", K_CNT, 0, 1);
    settle();
    rdy_in = 1'b0;
    #1 rst_in = 1'b0;
    set_rd(5'd7, 5'd5);
    exp_rd("arst_r7", 0, 0, 0, 0);
    exp_rd("arst_r5", 1, 0, 0, 0);
    push("arst_cnt", K_CNT, 0, 0);
    settle();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
